// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared stage-register constants and the skid-buffer state encoding.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int          DATA_W        = 32;
    localparam logic [31:0] DEF_RESET_VAL = 32'h0;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with asynchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline stage register with flush and optional
//            2-entry skid buffer. Define PIPE_STAGE_REG_STALL_CNT_EN to add
//            the stall_cnt output.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    parameter int               SKID      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    generate
        if (SKID != 0) begin : g_skid
            ps_state_t        state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_ready_q, in_ready_d;
            logic             xfer_in, xfer_out;

            assign xfer_in  = in_valid && in_ready_q;
            assign xfer_out = (state_q != PS_EMPTY) && out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end else begin
                    case (state_q)
                        PS_EMPTY: begin
                            if (xfer_in) begin
                                main_d  = in_data;
                                state_d = PS_ONE;
                            end
                        end
                        PS_ONE: begin
                            if (xfer_in && xfer_out) begin
                                main_d = in_data;
                            end else if (xfer_in) begin
                                skid_d  = in_data;
                                state_d = PS_FULL;
                            end else if (xfer_out) begin
                                state_d = PS_EMPTY;
                            end
                        end
                        PS_FULL: begin
                            if (xfer_out) begin
                                main_d  = skid_q;
                                state_d = PS_ONE;
                            end
                        end
                        default: begin
                            state_d = PS_EMPTY;
                        end
                    endcase
                end
                // Registered ready: a stall never ripples combinationally upstream.
                in_ready_d = (state_d != PS_FULL);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q    <= PS_EMPTY;
                    main_q     <= RESET_VAL;
                    skid_q     <= RESET_VAL;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != PS_EMPTY);
            assign out_data  = main_q;
        end else begin : g_noskid
            logic [WIDTH-1:0] main_q, main_d;
            logic             valid_q, valid_d;
            logic             ready_w;

            assign ready_w = out_ready || !valid_q;

            always_comb begin
                main_d  = main_q;
                valid_d = valid_q;
                if (flush) begin
                    main_d  = RESET_VAL;
                    valid_d = 1'b0;
                end else if (in_valid && ready_w) begin
                    main_d  = in_data;
                    valid_d = 1'b1;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q  <= RESET_VAL;
                    valid_q <= 1'b0;
                end else begin
                    main_q  <= main_d;
                    valid_q <= valid_d;
                end
            end

            assign in_ready  = ready_w;
            assign out_valid = valid_q;
            assign out_data  = main_q;
        end
    endgenerate

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    sat_counter #(
        .W (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg in SKID=1 and SKID=0 modes.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [31:0] idata = 32'h0;

    logic        ir_a, ov_a, ir_b, ov_b;
    logic [31:0] od_a, od_b;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [31:0] sc_a, sc_b;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (iv),
        .in_ready  (ir_a),
        .in_data   (idata),
        .out_valid (ov_a),
        .out_ready (ordy),
        .out_data  (od_a)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        ,
        .stall_cnt (sc_a)
`endif
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(0)) u_noskid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (iv),
        .in_ready  (ir_b),
        .in_data   (idata),
        .out_valid (ov_b),
        .out_ready (ordy),
        .out_data  (od_b)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        ,
        .stall_cnt (sc_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: per instance (0 = skid, 1 = no skid) an ordered list of held
    // words plus the value shown on out_data while nothing is held.
    int          m_cnt   [2];
    logic [31:0] m_ent   [2][2];
    logic [31:0] m_idle  [2];
    int unsigned m_stall [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int d);
        if (d == 0) return (m_cnt[0] < 2);
        return ordy || (m_cnt[1] == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]   = 0;
            m_idle[d]  = 32'h0;
            m_stall[d] = 0;
        end
    endtask

    function automatic logic [31:0] exp_data(input int d);
        return (m_cnt[d] > 0) ? m_ent[d][0] : m_idle[d];
    endfunction

    // Drive one cycle's inputs at the falling edge, then compare every output.
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] dt, input logic o);
        @(negedge clk);
        rst = r; flush = f; iv = v; idata = dt; ordy = o;
        #1;
        if (!r) model_reset();
        chk("skid.in_ready",    32'(ir_a), 32'(exp_ready(0)));
        chk("skid.out_valid",   32'(ov_a), 32'(m_cnt[0] > 0));
        chk("skid.out_data",    od_a,      exp_data(0));
        chk("noskid.in_ready",  32'(ir_b), 32'(exp_ready(1)));
        chk("noskid.out_valid", 32'(ov_b), 32'(m_cnt[1] > 0));
        chk("noskid.out_data",  od_b,      exp_data(1));
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        chk("skid.stall_cnt",   sc_a, m_stall[0]);
        chk("noskid.stall_cnt", sc_b, m_stall[1]);
`endif
    endtask

    // Advance the reference across the coming rising edge.
    task automatic commit();
        for (int d = 0; d < 2; d++) begin
            logic ov, acc, pop;
            ov  = (m_cnt[d] > 0);
            acc = iv && exp_ready(d);
            pop = ov && ordy;
            if (!rst) begin
                m_cnt[d]   = 0;
                m_idle[d]  = 32'h0;
                m_stall[d] = 0;
            end else begin
                if (ov && !ordy && m_stall[d] != 32'hFFFF_FFFF) m_stall[d]++;
                if (flush) begin
                    m_cnt[d]  = 0;
                    m_idle[d] = 32'h0;
                end else begin
                    if (pop) begin
                        if (m_cnt[d] == 1 && !acc) m_idle[d] = m_ent[d][0];
                        m_ent[d][0] = m_ent[d][1];
                        m_cnt[d]--;
                    end
                    if (acc) begin
                        m_ent[d][m_cnt[d]] = idata;
                        m_cnt[d]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] dt, input logic o);
        cyc(r, f, v, dt, o);
        commit();
    endtask

    initial begin
        model_reset();

        // Reset held with a pending input; nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
            chk("rst.out_valid", 32'(ov_a), 32'd0);
            chk("rst.out_data",  od_a,      32'd0);
            chk("rst.in_ready",  32'(ir_a), 32'd1);
            commit();
        end
        step(1'b1, 1'b0, 1'b1, 32'h11, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("first.out_valid", 32'(ov_a), 32'd1);
        chk("first.out_data",  od_a,      32'h11);
        commit();

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'(i), 1'b1);
            chk("stream.in_ready", 32'(ir_a), 32'd1);
            if (i > 1) chk("stream.out_data", od_a, 32'(i - 1));
            commit();
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream.last", od_a, 32'h8);
        commit();

        // Backpressure fills the skid entry.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        chk("bp.noskid_ready_low", 32'(ir_b), 32'd0);
        commit();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("bp.full_ready", 32'(ir_a), 32'd0);
        chk("bp.hold_A",     od_a,      32'hA);
        commit();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp.out_A", od_a, 32'hA);
        commit();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp.out_B",       od_a,      32'hB);
        chk("bp.ready_again", 32'(ir_a), 32'd1);
        commit();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush from FULL beats a simultaneous input.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hC, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush.skid_valid",   32'(ov_a), 32'd0);
        chk("flush.skid_data",    od_a,      32'd0);
        chk("flush.noskid_valid", 32'(ov_b), 32'd0);
        chk("flush.noskid_data",  od_b,      32'd0);
        commit();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Single-register mode replaces a held word in one cycle.
        step(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h6, 1'b1);
        chk("noskid.hold_5",  od_b,      32'h5);
        chk("noskid.ready_1", 32'(ir_b), 32'd1);
        commit();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("noskid.valid_6", 32'(ov_b), 32'd1);
        chk("noskid.data_6",  od_b,      32'h6);
        commit();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall.seven", sc_a, 32'd7);
        commit();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall.async_clear", sc_a, 32'd0);
        commit();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom,
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
